// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO feeding an 8N1 UART serializer (LSB first) on the SOC I/O bus.
//   The processor writes bytes with a one-cycle strobe; the serializer drains
//   the FIFO and sends frames back to back while data is available.
//
// Parameters
//   BAUD_DIV  clock cycles per serial bit (>= 2)
//   DEPTH     FIFO entries (power of two, >= 2)
//
// Ports
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset
//   wr_en      single-cycle write strobe
//   wr_data    byte to enqueue, sampled with wr_en
//   clr_ovf    clears the sticky overflow flag
//   TX         serial line, idles high, driven from a register
//   busy       frame in flight or FIFO non-empty
//   full       FIFO occupancy equals DEPTH
//   level      FIFO occupancy
//   overflow   sticky: a write was dropped because the FIFO was full
//   state_dbg  current serializer state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: there is no back-pressure on the write port. A write is taken
// on any rising edge where wr_en=1 and full=0; a write seen while full=1 is
// discarded and recorded in overflow. full is the pre-edge value, so a pop
// in the same cycle does not make room for that write.
module uart_tx_fifo #(
  parameter int BAUD_DIV = 16,
  parameter int DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       clr_ovf,
  output logic                       TX,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [1:0]                 state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          push, pop;

  // Serializer state
  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_q, tx_n;
  logic          bit_last;

  assign full      = (count == LW'(DEPTH));
  assign push      = wr_en && !full;
  assign level     = count;
  assign busy      = (state != IDLE) || (count != '0);
  assign TX        = tx_q;
  assign state_dbg = state;
  assign bit_last  = (baud_cnt == BAUD_LAST);

  // FIFO write side: storage is not reset, only the pointers are.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped write in the same cycle as a clear keeps the flag set.
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
    end
  end

  // Serializer registers. tx_q reset high so the line goes idle the moment
  // RESET asserts, even mid-frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  // Next-state logic. tx_n is the line value for the state being entered,
  // so TX changes on the same edge as the state it belongs to.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx_q;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          pop        = 1'b1;
          shift_n    = mem[rd_ptr];
          state_n    = START;
          baud_cnt_n = '0;
          tx_n       = 1'b0;
        end
      end

      START: begin
        if (bit_last) begin
          state_n    = DATA;
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          tx_n       = shift[0];
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
          tx_n       = 1'b0;
        end
      end

      DATA: begin
        if (bit_last) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
          tx_n       = shift[0];
        end
      end

      STOP: begin
        if (bit_last) begin
          baud_cnt_n = '0;
          if (count != '0) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
          tx_n       = 1'b1;
        end
      end

      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        tx_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with BAUD_DIV=4, DEPTH=4.
// The reference model works at frame level: a queue of pending bytes and a
// countdown of cycles left in the frame on the wire. The expected TX value
// is looked up from the 10-bit frame {stop, data, start} by elapsed time.
module tb_uart_tx_fifo;

  localparam int B     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * B;

  logic       CLK;
  logic       RESET;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       TX;
  logic       busy;
  logic       full;
  logic [2:0] level;
  logic       overflow;
  logic [1:0] state_dbg;

  uart_tx_fifo #(.BAUD_DIV(B), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .TX        (TX),
    .busy      (busy),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];      // bytes waiting in the FIFO
  int         frame_rem;     // cycles left in the frame on the wire, 0 = idle
  logic [7:0] cur_byte;
  logic       exp_ovf;
  int         vectors;
  int         miscompares;
  int         frames_started;

  function automatic void model_reset();
    exp_q.delete();
    frame_rem = 0;
    cur_byte  = 8'h00;
    exp_ovf   = 1'b0;
  endfunction

  // One clock edge with the given pre-edge inputs.
  function automatic void model_edge(input logic we, input logic [7:0] d, input logic co);
    bit was_full;
    was_full = (exp_q.size() == D);
    if ((frame_rem <= 1) && (exp_q.size() > 0)) begin
      cur_byte  = exp_q.pop_front();
      frame_rem = FRAME;
      frames_started++;
    end else if (frame_rem > 0) begin
      frame_rem--;
    end
    if (we && !was_full) exp_q.push_back(d);
    if (we && was_full) exp_ovf = 1'b1;
    else if (co)        exp_ovf = 1'b0;
  endfunction

  function automatic logic exp_tx();
    logic [9:0] frame;
    int pos;
    if (frame_rem == 0) return 1'b1;
    frame = {1'b1, cur_byte, 1'b0};
    pos   = (FRAME - frame_rem) / B;
    return frame[pos];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tx",       {7'd0, TX},       {7'd0, exp_tx()});
    chk("busy",     {7'd0, busy},     {7'd0, (frame_rem > 0) || (exp_q.size() > 0)});
    chk("full",     {7'd0, full},     {7'd0, exp_q.size() == D});
    chk("level",    {5'd0, level},    8'(exp_q.size()));
    chk("overflow", {7'd0, overflow}, {7'd0, exp_ovf});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic we, input logic [7:0] d, input logic co);
    wr_en   = we;
    wr_data = d;
    clr_ovf = co;
    @(posedge CLK);
    model_edge(we, d, co);
    #1;
    check_all();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fs0;
    vectors        = 0;
    miscompares    = 0;
    frames_started = 0;
    RESET   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    model_reset();
    #12;
    RESET = 1'b0;
    #1;
    // Reset values
    check_all();
    chk("state_idle", {6'd0, state_dbg}, 8'd0);

    // Idle stability
    idle(100);

    // Single byte 0xA5
    step(1'b1, 8'hA5, 1'b0);
    idle(FRAME + 5);

    // Back-to-back 0x55 then 0x0F
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h0F, 1'b0);
    idle(2 * FRAME + 5);

    // Overflow: six writes on consecutive edges, the sixth dropped
    fs0 = frames_started;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    chk("ovf_set", {7'd0, overflow}, 8'd1);
    idle(5 * FRAME + 5);
    chk("ovf_frames", 8'(frames_started - fs0), 8'd5);

    // Clear precedence: plain clear, then clear together with a dropped write
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr", {7'd0, overflow}, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("ovf_set_wins", {7'd0, overflow}, 8'd1);
    step(1'b0, 8'h00, 1'b1);
    idle(5 * FRAME + 5);

    // Randomized traffic in phases of differing write density
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(0, 8 * p + 3) == 0),
             8'($urandom_range(0, 255)),
             ($urandom_range(0, 31) == 0));
      end
    end
    idle(5 * FRAME + 5);

    // Reset mid-frame with two bytes queued
    step(1'b1, 8'h81, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h24, 1'b0);
    idle(B + 3);
    chk("pre_rst_level", {5'd0, level}, 8'd2);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check_all();
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Memory-mapped serial transmitter on the SOC I/O bus, the output path that carries program data off-chip alongside the LED port. The processor writes bytes into a small FIFO, and the block serializes them as 8N1 UART frames on `TX`, LSB first. It exposes `busy`, `full` and `level` status for polling, plus a sticky overflow flag. It runs in the divided SOC clock domain and sits next to the LED register in the SOC I/O decoder.

## Interface
- `BAUD_DIV`, default 16: clock cycles per serial bit. Legal range is ≥ 2.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and ≥ 2.
- `CLK`  in  1: system clock. All logic is on the rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: single-cycle write strobe from the I/O decoder.
- `wr_data`  in  8: byte to transmit. Sampled when `wr_en` is high.
- `clr_ovf`  in  1: clears `overflow`.
- `TX`  out  1: serial line. Idles high.
- `busy`  out  1: high when a frame is in flight or the FIFO is non-empty.
- `full`  out  1: high when FIFO level equals `DEPTH`.
- `level`  out  clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky flag. Set when a write is dropped.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers and an occupancy counter.
  - A write is accepted when `wr_en=1` and `full=0`.
  - `full` is evaluated before any same-cycle pop. A write in a full cycle is therefore dropped even if a pop also occurs that cycle, and `overflow` is set.
  - Simultaneous accepted write and pop leaves `level` unchanged.
  - Pointers wrap modulo `DEPTH`.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `TX=1`. If `level>0`, pop the head into the shift register and go to START.
  - START: `TX=0` for `BAUD_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `TX` = shift[0] for `BAUD_DIV` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `TX=1` for `BAUD_DIV` cycles. On the last STOP cycle:
    - if `level>0`, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- **Baud counter:** counts 0..`BAUD_DIV`-1 and reloads to 0 on each bit boundary. Its width is clog2(`BAUD_DIV`).
- **`overflow`:** set by a dropped write and cleared by `clr_ovf`. If set and clear occur in the same cycle, set wins.
- **`busy`** = (state≠IDLE) OR (`level`≠0). It is combinational from registered state.
- **`TX`** is driven from a register, so it is glitch-free.

## Timing
- **Reset values:** `TX=1`, `busy=0`, `full=0`, `level=0`, `overflow=0`, state IDLE, pointers 0, baud counter 0.
- **Reset mid-frame** aborts the frame and empties the FIFO. `TX` goes high asynchronously on assertion of `RESET`.
- **Write latency:** a write captured at edge E0 raises `level` after E0. At E1 the FSM pops it (if IDLE), and `TX` is low after E1. `busy` is high from after E0.
- **Frame length** is exactly 10×`BAUD_DIV` cycles, from `TX` falling to the end of the stop bit.
- **Back-to-back frames** occupy 10×`BAUD_DIV` cycles each, with no extra cycles between the stop bit and the next start bit.
- **Writes during a frame** are accepted every cycle until `full` is reached.

## Test plan
All scenarios use `BAUD_DIV=4` and `DEPTH=4`.
- **Single byte:** write 0xA5 at E0 → from E1, `TX` is:
  - 0 for 4 cycles (start);
  - bits 1,0,1,0,0,1,0,1 for 4 cycles each;
  - 1 for 4 cycles (stop).

  `busy` falls after 40 cycles of frame, and `level` returns to 0 after E1.
- **Back-to-back:** write 0x55 then 0x0F on consecutive cycles → two frames, 80 contiguous cycles. The start bit of 0x0F immediately follows the stop bit of 0x55. `TX` never idles between them.
- **Overflow:** write 6 bytes on consecutive edges E0–E5 →
  - byte 0 is popped at E1;
  - `level` reaches 4 and `full=1` after E4;
  - byte 5 is dropped and `overflow=1` after E5;
  - exactly 5 frames are transmitted.
- **Clear precedence:** with `overflow=1`, pulse `clr_ovf` → 0 after the edge. Pulse `clr_ovf` in the same cycle as a dropped write → stays 1.
- **Reset mid-frame:** assert `RESET` during the DATA state with 2 bytes queued → `TX=1` immediately, and `level=0`, `busy=0`. After deassertion, `TX` stays high with no further frames.
- **Idle stability:** run 100 cycles with no writes after reset → `TX=1` throughout and `busy=0`.
